// File: rtl/tim_regs_if.sv
// Bus-side interface of the TIM register file:
// select, strobes, address/data and the registered read return.
interface tim_regs_if;
    logic        sel;
    logic        bus_we;
    logic        bus_re;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;

    modport master (
        output sel, bus_we, bus_re, bus_addr, bus_wdata,
        input  bus_rdata, bus_rvalid
    );

    modport slave (
        input  sel, bus_we, bus_re, bus_addr, bus_wdata,
        output bus_rdata, bus_rvalid
    );
endinterface

// File: rtl/tim_regs.sv
// TIM timer/PWM register file: control, status, preload/active
// timing registers, update-event copy and level interrupt.
module tim_regs #(
    parameter int               TIM_W   = 16,
    parameter logic [TIM_W-1:0] RST_ARR = 16'hFFFF,
    parameter logic [TIM_W-1:0] RST_PSC = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    tim_regs_if.slave        bus,
    input  logic [TIM_W-1:0] tim_cnt,
    input  logic             upd_evt,
    output logic             timer_en,
    output logic             countdown,
    output logic [TIM_W-1:0] tim_psc,
    output logic [TIM_W-1:0] tim_arr,
    output logic [TIM_W-1:0] tim_ccr1,
    output logic [TIM_W-1:0] tim_ccr2,
    output logic             irq
);

    localparam logic [2:0] IDX_CR   = 3'd0;
    localparam logic [2:0] IDX_SR   = 3'd1;
    localparam logic [2:0] IDX_PSC  = 3'd2;
    localparam logic [2:0] IDX_ARR  = 3'd3;
    localparam logic [2:0] IDX_CCR1 = 3'd4;
    localparam logic [2:0] IDX_CCR2 = 3'd5;
    localparam logic [2:0] IDX_CNT  = 3'd6;
    localparam logic [2:0] IDX_EGR  = 3'd7;

    // CR bit positions: {UIE, ARPE, DIR, CEN}
    logic [3:0]       cr_q, cr_d;
    logic             uif_q, uif_d;
    logic [TIM_W-1:0] psc_pre_q, psc_pre_d, psc_q, psc_d;
    logic [TIM_W-1:0] arr_pre_q, arr_pre_d, arr_q, arr_d;
    logic [TIM_W-1:0] c1_pre_q, c1_pre_d, c1_q, c1_d;
    logic [TIM_W-1:0] c2_pre_q, c2_pre_d, c2_q, c2_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    logic             wr, rd, upd;
    logic [2:0]       idx;
    logic [TIM_W-1:0] wval;
    logic [31:0]      rmux;
    logic             unused_bits;

    assign idx  = bus.bus_addr[4:2];
    assign wr   = bus.sel & bus.bus_we;
    assign rd   = bus.sel & bus.bus_re;
    assign wval = bus.bus_wdata[TIM_W-1:0];
    assign upd  = upd_evt | (wr && idx == IDX_EGR && bus.bus_wdata[0]);

    assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata[31:TIM_W]};

    always_comb begin
        rmux = '0;
        unique case (idx)
            IDX_CR:   rmux[3:0]       = cr_q;
            IDX_SR:   rmux[0]         = uif_q;
            IDX_PSC:  rmux[TIM_W-1:0] = psc_pre_q;
            IDX_ARR:  rmux[TIM_W-1:0] = arr_pre_q;
            IDX_CCR1: rmux[TIM_W-1:0] = c1_pre_q;
            IDX_CCR2: rmux[TIM_W-1:0] = c2_pre_q;
            IDX_CNT:  rmux[TIM_W-1:0] = tim_cnt;
            IDX_EGR:  rmux            = '0;
        endcase
    end

    always_comb begin
        cr_d      = cr_q;
        uif_d     = uif_q;
        psc_pre_d = psc_pre_q;
        arr_pre_d = arr_pre_q;
        c1_pre_d  = c1_pre_q;
        c2_pre_d  = c2_pre_q;
        psc_d     = upd ? psc_pre_q : psc_q;
        arr_d     = upd ? arr_pre_q : arr_q;
        c1_d      = upd ? c1_pre_q  : c1_q;
        c2_d      = upd ? c2_pre_q  : c2_q;
        rvalid_d  = rd;
        rdata_d   = rd ? rmux : rdata_q;

        if (wr) begin
            unique case (idx)
                IDX_CR:   cr_d = bus.bus_wdata[3:0];
                IDX_SR:   if (bus.bus_wdata[0]) uif_d = 1'b0;
                IDX_PSC:  psc_pre_d = wval;
                IDX_ARR: begin
                    arr_pre_d = wval;
                    // without ARPE the write bypasses the shadow
                    if (!cr_q[2]) arr_d = wval;
                end
                IDX_CCR1: c1_pre_d = wval;
                IDX_CCR2: c2_pre_d = wval;
                IDX_CNT, IDX_EGR: ;
            endcase
        end

        if (upd_evt) uif_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cr_q      <= '0;
            uif_q     <= 1'b0;
            psc_pre_q <= RST_PSC;
            psc_q     <= RST_PSC;
            arr_pre_q <= RST_ARR;
            arr_q     <= RST_ARR;
            c1_pre_q  <= '0;
            c1_q      <= '0;
            c2_pre_q  <= '0;
            c2_q      <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            cr_q      <= cr_d;
            uif_q     <= uif_d;
            psc_pre_q <= psc_pre_d;
            psc_q     <= psc_d;
            arr_pre_q <= arr_pre_d;
            arr_q     <= arr_d;
            c1_pre_q  <= c1_pre_d;
            c1_q      <= c1_d;
            c2_pre_q  <= c2_pre_d;
            c2_q      <= c2_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign bus.bus_rdata  = rdata_q;
    assign bus.bus_rvalid = rvalid_q;
    assign timer_en  = cr_q[0];
    assign countdown = cr_q[1];
    assign tim_psc   = psc_q;
    assign tim_arr   = arr_q;
    assign tim_ccr1  = c1_q;
    assign tim_ccr2  = c2_q;
    assign irq       = uif_q & cr_q[3];

endmodule

// File: tb/tb_tim_regs.sv
// Directed bench for tim_regs: vector table for the register map
// plus short sequences for reset/read timing corners.
module tb_tim_regs;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] tim_cnt;
    logic        upd_evt;
    logic        timer_en, countdown, irq;
    logic [15:0] tim_psc, tim_arr, tim_ccr1, tim_ccr2;

    int n_tests = 0;
    int n_fail  = 0;

    tim_regs_if bus ();

    tim_regs dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .tim_cnt   (tim_cnt),
        .upd_evt   (upd_evt),
        .timer_en  (timer_en),
        .countdown (countdown),
        .tim_psc   (tim_psc),
        .tim_arr   (tim_arr),
        .tim_ccr1  (tim_ccr1),
        .tim_ccr2  (tim_ccr2),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sel, we, re, upd;
        logic [2:0]  idx;
        logic [31:0] wd;
        logic [15:0] psc, arr, c1, c2;
        bit          irq;
        logic [1:0]  cd;
        bit          rv;
        logic [31:0] rd;
    } vec_t;

    vec_t vq[$];

    function automatic void add(bit sel, bit we, bit re, bit upd,
                                logic [2:0] idx, logic [31:0] wd,
                                logic [15:0] psc, logic [15:0] arr,
                                logic [15:0] c1, logic [15:0] c2,
                                bit irq_e, logic [1:0] cd,
                                bit rv, logic [31:0] rd);
        vec_t v;
        v.sel = sel; v.we = we; v.re = re; v.upd = upd;
        v.idx = idx; v.wd = wd;
        v.psc = psc; v.arr = arr; v.c1 = c1; v.c2 = c2;
        v.irq = irq_e; v.cd = cd; v.rv = rv; v.rd = rd;
        vq.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.sel = 1'b0; bus.bus_we = 1'b0; bus.bus_re = 1'b0;
        bus.bus_addr = '0; bus.bus_wdata = '0; upd_evt = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tim_cnt = 16'h1234;
        idle();

        // reset-state reads of every index
        add(1,0,1,0,0,0, 0,16'hFFFF,0,0, 0,0, 1,32'h0);
        add(1,0,1,0,1,0, 0,16'hFFFF,0,0, 0,0, 1,32'h0);
        add(1,0,1,0,2,0, 0,16'hFFFF,0,0, 0,0, 1,32'h0);
        add(1,0,1,0,3,0, 0,16'hFFFF,0,0, 0,0, 1,32'hFFFF);
        add(1,0,1,0,4,0, 0,16'hFFFF,0,0, 0,0, 1,32'h0);
        add(1,0,1,0,5,0, 0,16'hFFFF,0,0, 0,0, 1,32'h0);
        add(1,0,1,0,6,0, 0,16'hFFFF,0,0, 0,0, 1,32'h1234);
        add(1,0,1,0,7,0, 0,16'hFFFF,0,0, 0,0, 1,32'h0);
        // preload of PSC/CCR1, copy on update
        add(1,1,0,0,2,7,   0,16'hFFFF,0,0,   0,0, 0,0);
        add(1,1,0,0,4,100, 0,16'hFFFF,0,0,   0,0, 0,0);
        add(0,0,0,1,0,0,   7,16'hFFFF,100,0, 0,0, 0,0);
        add(1,0,1,0,1,0,   7,16'hFFFF,100,0, 0,0, 1,32'h1);
        add(1,1,0,0,1,1,   7,16'hFFFF,100,0, 0,0, 0,0);
        add(1,0,1,0,1,0,   7,16'hFFFF,100,0, 0,0, 1,32'h0);
        // ARR direct vs preloaded, UG forced copy
        add(1,1,0,0,3,50, 7,50,100,0, 0,0, 0,0);
        add(1,1,0,0,0,4,  7,50,100,0, 0,0, 0,0);
        add(1,1,0,0,3,80, 7,50,100,0, 0,0, 0,0);
        add(1,0,1,0,3,0,  7,50,100,0, 0,0, 1,32'd80);
        add(1,1,0,0,7,1,  7,80,100,0, 0,0, 0,0);
        add(1,0,1,0,1,0,  7,80,100,0, 0,0, 1,32'h0);
        add(1,0,1,0,7,0,  7,80,100,0, 0,0, 1,32'h0);
        // interrupt and W1C
        add(1,1,0,0,1'b0,32'hC, 7,80,100,0, 0,0, 0,0);
        add(0,0,0,1,0,0,  7,80,100,0, 1,0, 0,0);
        add(1,1,0,0,1,0,  7,80,100,0, 1,0, 0,0);
        add(1,1,0,1,1,1,  7,80,100,0, 1,0, 0,0);
        add(1,1,0,0,1,1,  7,80,100,0, 0,0, 0,0);
        // CCR2 write colliding with update
        add(1,1,0,1,5,75, 7,80,100,0,  1,0, 0,0);
        add(0,0,0,1,0,0,  7,80,100,75, 1,0, 0,0);
        add(1,1,0,0,1,1,  7,80,100,75, 0,0, 0,0);
        // deselected strobes are ignored
        add(0,1,1,0,2,99, 7,80,100,75, 0,0, 0,0);
        add(1,0,1,1,2,0,  7,80,100,75, 1,0, 1,32'd7);
        // simultaneous write and read returns the old value
        add(1,1,1,0,2,9,  7,80,100,75, 1,0, 1,32'd7);
        add(1,0,1,0,2,0,  7,80,100,75, 1,0, 1,32'd9);
        // CNT writes ignored, CR upper bits dropped
        add(1,1,0,0,6,5,  7,80,100,75, 1,0, 0,0);
        add(1,1,0,0,0,32'hFFFF_FFF3, 7,80,100,75, 0,3, 0,0);
        add(1,0,1,0,0,0,  7,80,100,75, 0,3, 1,32'h3);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_psc",    32'(tim_psc), 32'h0);
        chk("rst_arr",    32'(tim_arr), 32'hFFFF);
        chk("rst_irq",    32'(irq), 32'h0);
        chk("rst_rvalid", 32'(bus.bus_rvalid), 32'h0);
        chk("rst_rdata",  bus.bus_rdata, 32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            bus.sel       = vq[i].sel;
            bus.bus_we    = vq[i].we;
            bus.bus_re    = vq[i].re;
            bus.bus_addr  = {vq[i].idx, 2'b00};
            bus.bus_wdata = vq[i].wd;
            upd_evt       = vq[i].upd;
            @(posedge clk);
            #1;
            idle();
            chk($sformatf("v%0d_psc", i),  32'(tim_psc),  32'(vq[i].psc));
            chk($sformatf("v%0d_arr", i),  32'(tim_arr),  32'(vq[i].arr));
            chk($sformatf("v%0d_ccr1", i), 32'(tim_ccr1), 32'(vq[i].c1));
            chk($sformatf("v%0d_ccr2", i), 32'(tim_ccr2), 32'(vq[i].c2));
            chk($sformatf("v%0d_irq", i),  32'(irq),      32'(vq[i].irq));
            chk($sformatf("v%0d_cr", i),
                32'({countdown, timer_en}), 32'(vq[i].cd));
            chk($sformatf("v%0d_rvalid", i),
                32'(bus.bus_rvalid), 32'(vq[i].rv));
            if (vq[i].rv)
                chk($sformatf("v%0d_rdata", i), bus.bus_rdata, vq[i].rd);
        end

        // reset in the read cycle drops rvalid and restores defaults
        bus.sel = 1'b1; bus.bus_re = 1'b1; bus.bus_addr = 5'd24;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        chk("rstrd_rvalid", 32'(bus.bus_rvalid), 32'h0);
        chk("rstrd_rdata",  bus.bus_rdata, 32'h0);
        chk("rstrd_psc",    32'(tim_psc), 32'h0);
        chk("rstrd_arr",    32'(tim_arr), 32'hFFFF);
        chk("rstrd_cr",     32'({countdown, timer_en}), 32'h0);

        // ARR write with ARPE=0 during update takes the new value
        bus.sel = 1'b1; bus.bus_we = 1'b1;
        bus.bus_addr = 5'd12; bus.bus_wdata = 32'h22;
        upd_evt = 1'b1;
        @(posedge clk);
        #1;
        idle();
        chk("arr_coll", 32'(tim_arr), 32'h22);
        chk("arr_coll_irq", 32'(irq), 32'h0);

        // read latency and rdata hold
        tim_cnt = 16'hBEEF;
        bus.sel = 1'b1; bus.bus_re = 1'b1; bus.bus_addr = 5'd24;
        @(posedge clk);
        #1;
        idle();
        tim_cnt = 16'h0001;
        chk("lat_rvalid1", 32'(bus.bus_rvalid), 32'h1);
        chk("lat_rdata1",  bus.bus_rdata, 32'h0000BEEF);
        @(posedge clk);
        #1;
        chk("lat_rvalid2", 32'(bus.bus_rvalid), 32'h0);
        chk("lat_hold",    bus.bus_rdata, 32'h0000BEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
